wishbone_master_burst: RTL and testbench
========================================

Name: wishbone_master_burst

Overview:
Parametrised Wishbone B4 classic master. It runs single or incrementing-burst reads and writes issued through a command handshake. It streams write data in and read data out, and reports completion, bus error and timeout. It is the general-purpose bus initiator between user logic (UART/LED/test controllers) and the Wishbone interconnect on the Tang Nano designs.

Parameters:
ADDR_W, 32, address bus width
DATA_W, 32, data bus width (multiple of 8)
SEL_W, DATA_W/8, byte-select width; also the byte address increment per beat
LEN_W, 4, burst length field width; beats = cmd_len_i+1 (max 16 at default)
TIMEOUT, 255, max cycles stb_o may wait for ack_i/err_i; 0 disables timeout
TO_W, 8, timeout counter width (must hold TIMEOUT)

Ports:
clk_i  in  1  clock, all logic on rising edge
rst_i  in  1  synchronous reset, active-high
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  high only in IDLE
cmd_we_i  in  1  1=write, 0=read
cmd_addr_i  in  ADDR_W  start byte address
cmd_len_i  in  LEN_W  beats minus one
cmd_sel_i  in  SEL_W  byte selects for every beat
wr_data_i  in  DATA_W  write data word
wr_valid_i  in  1  write word available
wr_ready_o  out  1  write word accepted when wr_valid_i & wr_ready_o
rd_data_o  out  DATA_W  read word
rd_valid_o  out  1  one-cycle pulse per read beat, no backpressure
done_o  out  1  one-cycle pulse at end of command
err_o  out  1  valid with done_o: command ended by err_i or timeout
timeout_o  out  1  valid with done_o: command ended by timeout
adr_o  out  ADDR_W  Wishbone address
dat_o  out  DATA_W  Wishbone write data
dat_i  in  DATA_W  Wishbone read data
we_o  out  1  Wishbone write enable
sel_o  out  SEL_W  Wishbone byte select
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
ack_i  in  1  Wishbone acknowledge
err_i  in  1  Wishbone error

Behaviour:
- All outputs registered. Reset: state IDLE; every output 0 except cmd_ready_o=1. Beat and timeout counters 0.
- Reset mid-command: cyc_o/stb_o low the cycle after the reset edge. No done_o. Remaining beats discarded.
- IDLE: cmd_ready_o=1, cyc_o=stb_o=0.
  - On cmd_valid_i, latch addr/we/sel/len and drop cmd_ready_o.
  - Read: go to STROBE; cyc_o=stb_o=1 in the next cycle.
  - Write: go to WDATA.
- WDATA: cyc_o=1, stb_o=0, wr_ready_o=1.
  - On wr_valid_i, dat_o<=wr_data_i and go to STROBE.
  - No timeout here; cyc_o stays held while waiting for data.
- STROBE: cyc_o=stb_o=1, wr_ready_o=0, timeout counter increments each cycle.
  - err_i (priority over simultaneous ack_i): go to DONE with err_o=1. No rd_valid_o for that beat.
  - ack_i on a read: rd_data_o<=dat_i, and rd_valid_o=1 in the next cycle.
  - ack_i on the last beat: go to DONE.
  - ack_i on any other beat: adr_o+=SEL_W (wraps modulo 2^ADDR_W), remaining-=1, timeout counter cleared.
    - Read: stay in STROBE; stb_o stays high with the new address.
    - Write: go to WDATA; stb_o drops.
  - Timeout: TIMEOUT!=0 and counter==TIMEOUT with no ack_i/err_i → go to DONE with err_o=timeout_o=1. stb_o is high for exactly TIMEOUT cycles.
- DONE: cyc_o=stb_o=0, done_o=1 for one cycle, err_o/timeout_o valid, then go to IDLE.
  - done_o coincides with the last rd_valid_o.
  - err_o/timeout_o cleared on the next command accept.
- Latency:
  - Read: cmd accept edge N → stb_o high at N+1. An ack sampled at edge M → rd_valid_o in cycle M+1.
  - Zero-wait slave: one beat per cycle.
- we_o and sel_o are constant for the whole command. Inputs other than ack_i/err_i/wr_valid_i are ignored outside their accept points.

Test Plan:
1. Single read: addr 0x100, len 0, sel 0xF; slave acks 2 cycles after stb with 0xDEADBEEF → adr_o=0x100, we_o=0, one rd_valid_o carrying 0xDEADBEEF, done_o in the same cycle, err_o=0.
2. 4-beat write at 0x200; wr_valid_i has 3-cycle gaps → adr_o 0x200/0x204/0x208/0x20C with matching dat_o; stb_o low in gaps; cyc_o continuous; single done_o.
3. 4-beat zero-wait read at 0x40 → stb_o high 4 consecutive cycles, 4 back-to-back rd_valid_o pulses, done_o with the 4th.
4. err_i on beat 2 of a 4-beat read; also ack_i and err_i together on a single read → exactly 1 (resp. 0) rd_valid_o, done_o with err_o=1 and timeout_o=0, cyc_o low in the next cycle.
5. Silent slave, TIMEOUT=8 → stb_o high exactly 8 cycles, then done_o with err_o=1 and timeout_o=1; a new command is accepted the following cycle.
6. Reset asserted during beat 2 of a burst → cyc_o/stb_o=0 the next cycle, no done_o, cmd_ready_o=1. Separately: addr 0xFFFFFFFC, len 1 → second beat adr_o=0x00000000.

Source files
------------

// File: rtl/wishbone_master_burst.sv
// Wishbone B4 classic bus master: single and incrementing-burst reads/writes
// issued through a command handshake, with streamed write/read data and error/timeout reporting.
module wishbone_master_burst #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = DATA_W / 8,
  parameter int LEN_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              done_o,
  output logic              err_o,
  output logic              timeout_o,
  output logic [ADDR_W-1:0] adr_o,
  output logic [DATA_W-1:0] dat_o,
  input  logic [DATA_W-1:0] dat_i,
  output logic              we_o,
  output logic [SEL_W-1:0]  sel_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic              ack_i,
  input  logic              err_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WDATA,
    S_STROBE,
    S_DONE
  } state_t;

  // The counter value seen during the last permitted strobe cycle, so stb_o is high exactly TIMEOUT cycles.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                we_q, we_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                wr_ready_q, wr_ready_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                timeout_q, timeout_d;

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    sel_d       = sel_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    remaining_d = remaining_q;
    to_cnt_d    = to_cnt_q;
    cmd_ready_d = cmd_ready_q;
    wr_ready_d  = wr_ready_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    done_d      = 1'b0;
    err_d       = err_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          adr_d       = cmd_addr_i;
          we_d        = cmd_we_i;
          sel_d       = cmd_sel_i;
          remaining_d = cmd_len_i;
          to_cnt_d    = '0;
          err_d       = 1'b0;
          timeout_d   = 1'b0;
          cmd_ready_d = 1'b0;
          cyc_d       = 1'b1;
          if (cmd_we_i) begin
            wr_ready_d = 1'b1;
            state_d    = S_WDATA;
          end else begin
            stb_d   = 1'b1;
            state_d = S_STROBE;
          end
        end
      end

      S_WDATA: begin
        if (wr_valid_i) begin
          dat_d      = wr_data_i;
          wr_ready_d = 1'b0;
          stb_d      = 1'b1;
          to_cnt_d   = '0;
          state_d    = S_STROBE;
        end
      end

      S_STROBE: begin
        to_cnt_d = to_cnt_q + TO_W'(1);
        if (err_i) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          state_d = S_DONE;
        end else if (ack_i) begin
          if (!we_q) begin
            rd_data_d  = dat_i;
            rd_valid_d = 1'b1;
          end
          if (remaining_q == '0) begin
            done_d  = 1'b1;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            // Reads keep strobing at the next address; writes go back for the next data word.
            adr_d       = adr_q + ADDR_W'(SEL_W);
            remaining_d = remaining_q - LEN_W'(1);
            to_cnt_d    = '0;
            if (we_q) begin
              stb_d      = 1'b0;
              wr_ready_d = 1'b1;
              state_d    = S_WDATA;
            end
          end
        end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          err_d     = 1'b1;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          cyc_d     = 1'b0;
          stb_d     = 1'b0;
          state_d   = S_DONE;
        end
      end

      S_DONE: begin
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end

      default: begin
        cyc_d       = 1'b0;
        stb_d       = 1'b0;
        wr_ready_d  = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      remaining_q <= '0;
      to_cnt_q    <= '0;
      cmd_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      remaining_q <= remaining_d;
      to_cnt_q    <= to_cnt_d;
      cmd_ready_q <= cmd_ready_d;
      wr_ready_q  <= wr_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign wr_ready_o  = wr_ready_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign timeout_o   = timeout_q;
  assign adr_o       = adr_q;
  assign dat_o       = dat_q;
  assign we_o        = we_q;
  assign sel_o       = sel_q;
  assign cyc_o       = cyc_q;
  assign stb_o       = stb_q;

endmodule

// File: tb/tb_wishbone_master_burst.sv
// Bench for wishbone_master_burst: a behavioural Wishbone slave and write-data source
// record each command, and the results are compared against expectations computed from the command itself.
module tb_wishbone_master_burst;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_we_i;
  logic [31:0] cmd_addr_i;
  logic [3:0]  cmd_len_i;
  logic [3:0]  cmd_sel_i;
  logic [31:0] wr_data_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [31:0] rd_data_o;
  logic        rd_valid_o;
  logic        done_o;
  logic        err_o;
  logic        timeout_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        ack_i;
  logic        err_i;

  wishbone_master_burst #(
    .ADDR_W(32), .DATA_W(32), .SEL_W(4), .LEN_W(4), .TIMEOUT(8), .TO_W(8)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we_i),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_sel_i(cmd_sel_i),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .done_o(done_o), .err_o(err_o), .timeout_o(timeout_o),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Slave behaviour for the current command.
  int          s_waits, s_err_beat, s_wr_gap;
  bit          s_both, s_silent, s_fixed_en;
  logic [31:0] s_fixed, salt;

  // Observations of the current command.
  logic [31:0] log_adr[$], log_dat[$], rd_q[$], wr_q[$], exp_words[$];
  logic [3:0]  log_sel[$];
  logic        log_we[$];
  int          ack_cyc[$], rd_cyc[$];
  int          cyc_n = 0, beat, wctr, gap_ctr, done_cnt, done_cyc, stb_cycles;
  int          first_stb, cyc_gaps, stb_gaps, accept_edge;
  bit          pend_acc, done_err, done_to;

  // Current command as issued.
  bit          c_we;
  logic [31:0] c_addr;
  int          c_len;
  logic [3:0]  c_sel;

  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave, write-data source and monitor, all sampling 1 time unit after the rising edge.
  initial begin
    ack_i = 1'b0; err_i = 1'b0; dat_i = '0; wr_valid_i = 1'b0; wr_data_i = '0;
    pend_acc = 1'b0; gap_ctr = 0; wctr = 0; beat = 0;
    forever begin
      @(posedge clk_i);
      #1;
      cyc_n++;
      if (pend_acc) begin
        if (wr_q.size() > 0) void'(wr_q.pop_front());
        pend_acc = 1'b0;
        gap_ctr  = 0;
      end
      if (rd_valid_o) begin
        rd_q.push_back(rd_data_o);
        rd_cyc.push_back(cyc_n);
      end
      if (done_o) begin
        done_cnt++;
        done_cyc = cyc_n;
        done_err = err_o;
        done_to  = timeout_o;
      end
      if (done_cnt == 0 && !done_o && cyc_n >= accept_edge) begin
        if (!cyc_o) cyc_gaps++;
        if (cyc_o && !stb_o) stb_gaps++;
      end
      if (stb_o) begin
        stb_cycles++;
        if (first_stb < 0) first_stb = cyc_n;
      end

      ack_i = 1'b0;
      err_i = 1'b0;
      if (!(cyc_o && stb_o)) begin
        wctr = 0;
      end else if (!s_silent) begin
        if (wctr < s_waits) begin
          wctr++;
        end else begin
          wctr  = 0;
          dat_i = s_fixed_en ? s_fixed : slave_data(adr_o);
          if (beat == s_err_beat) begin
            err_i = 1'b1;
            ack_i = s_both;
          end else begin
            ack_i = 1'b1;
            log_adr.push_back(adr_o);
            log_dat.push_back(dat_o);
            log_sel.push_back(sel_o);
            log_we.push_back(we_o);
            ack_cyc.push_back(cyc_n);
          end
          beat++;
        end
      end

      if (wr_q.size() > 0 && gap_ctr >= s_wr_gap) begin
        wr_valid_i = 1'b1;
        wr_data_i  = wr_q[0];
        pend_acc   = wr_ready_o;
      end else begin
        wr_valid_i = 1'b0;
        if (wr_q.size() > 0) gap_ctr++;
      end
    end
  end

  task automatic apply_stimulus(input bit we, input logic [31:0] addr, input int len,
                                input logic [3:0] sel, input int waits, input int err_beat,
                                input bit both, input bit silent, input int wr_gap);
    log_adr.delete(); log_dat.delete(); log_sel.delete(); log_we.delete();
    ack_cyc.delete(); rd_q.delete(); rd_cyc.delete(); wr_q.delete(); exp_words.delete();
    done_cnt = 0; stb_cycles = 0; first_stb = -1; cyc_gaps = 0; stb_gaps = 0;
    accept_edge = 1 << 30;
    beat = 0; wctr = 0; gap_ctr = 0; pend_acc = 1'b0;
    s_waits = waits; s_err_beat = err_beat; s_both = both; s_silent = silent; s_wr_gap = wr_gap;
    salt = $urandom;
    c_we = we; c_addr = addr; c_len = len; c_sel = sel;
    if (we) begin
      for (int i = 0; i <= len; i++) begin
        logic [31:0] w;
        w = $urandom;
        wr_q.push_back(w);
        exp_words.push_back(w);
      end
    end
    @(negedge clk_i);
    check_output("cmd_ready_idle", cmd_ready_o, 1);
    cmd_valid_i = 1'b1;
    cmd_we_i    = we;
    cmd_addr_i  = addr;
    cmd_len_i   = 4'(len);
    cmd_sel_i   = sel;
    accept_edge = cyc_n + 1;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    cmd_we_i    = 1'($urandom);
    cmd_addr_i  = $urandom;
    cmd_len_i   = 4'($urandom);
    cmd_sel_i   = 4'($urandom);
    check_output("err_clear_on_accept", {err_o, timeout_o}, 2'b00);
  endtask

  task automatic verify_cmd(input string tag);
    int g, n_ok, exp_stb;
    bit exp_err;
    g = 0;
    while (done_cnt == 0 && g < 500) begin
      @(negedge clk_i);
      g++;
    end
    check_output({tag, "_done_seen"}, done_cnt != 0, 1);
    exp_err = s_silent || (s_err_beat >= 0);
    n_ok    = s_silent ? 0 : ((s_err_beat >= 0) ? s_err_beat : c_len + 1);
    exp_stb = s_silent ? 8 : (n_ok + ((s_err_beat >= 0) ? 1 : 0)) * (s_waits + 1);
    check_output({tag, "_done_count"}, done_cnt, 1);
    check_output({tag, "_err_to"}, {done_err, done_to}, {exp_err, s_silent});
    check_output({tag, "_bus_idle_at_done"}, {done_o, cyc_o, stb_o}, 3'b100);
    check_output({tag, "_beats_acked"}, log_adr.size(), n_ok);
    for (int i = 0; i < n_ok && i < log_adr.size(); i++) begin
      logic [31:0] ea;
      ea = c_addr + 32'(4 * i);
      check_output($sformatf("%s_adr%0d", tag, i), log_adr[i], ea);
      check_output($sformatf("%s_we_sel%0d", tag, i), {log_we[i], log_sel[i]}, {c_we, c_sel});
      if (c_we) check_output($sformatf("%s_wdat%0d", tag, i), log_dat[i], exp_words[i]);
    end
    check_output({tag, "_stb_cycles"}, stb_cycles, exp_stb);
    check_output({tag, "_cyc_continuous"}, cyc_gaps, 0);
    if (!c_we) begin
      check_output({tag, "_stb_latency"}, first_stb, accept_edge);
      check_output({tag, "_rd_count"}, rd_q.size(), n_ok);
      for (int i = 0; i < n_ok && i < rd_q.size() && i < log_adr.size(); i++) begin
        check_output($sformatf("%s_rdat%0d", tag, i), rd_q[i],
                     s_fixed_en ? s_fixed : slave_data(log_adr[i]));
        if (i < ack_cyc.size())
          check_output($sformatf("%s_rd_lat%0d", tag, i), rd_cyc[i], ack_cyc[i] + 1);
      end
      if (s_silent) begin
        check_output({tag, "_timeout_cycle"}, done_cyc, accept_edge + 8);
      end else if (s_err_beat < 0) begin
        check_output({tag, "_done_cycle"}, done_cyc, accept_edge + (c_len + 1) * (s_waits + 1));
        if (rd_cyc.size() > 0) check_output({tag, "_done_with_last_rd"}, done_cyc, rd_cyc[rd_cyc.size() - 1]);
      end
    end else begin
      check_output({tag, "_no_rd_on_write"}, rd_q.size(), 0);
      if (s_wr_gap > 0 && n_ok > 1) check_output({tag, "_stb_low_in_gaps"}, stb_gaps != 0, 1);
    end
  endtask

  initial begin
    int g;
    rst_i = 1'b1;
    cmd_valid_i = 1'b0; cmd_we_i = 1'b0; cmd_addr_i = '0; cmd_len_i = '0; cmd_sel_i = '0;
    s_waits = 0; s_err_beat = -1; s_wr_gap = 0; s_both = 0; s_silent = 0; s_fixed_en = 0;
    s_fixed = '0; salt = '0; done_cnt = 0; accept_edge = 1 << 30; first_stb = -1;
    repeat (3) @(negedge clk_i);
    check_output("reset_ready", cmd_ready_o, 1);
    check_output("reset_bus", {cyc_o, stb_o, we_o, sel_o, adr_o}, '0);
    check_output("reset_flags", {wr_ready_o, rd_valid_o, done_o, err_o, timeout_o}, '0);
    rst_i = 1'b0;

    $display("[TB] single read with 2 wait states");
    s_fixed_en = 1'b1; s_fixed = 32'hDEAD_BEEF;
    apply_stimulus(0, 32'h100, 0, 4'hF, 2, -1, 0, 0, 0);
    verify_cmd("single_rd");
    s_fixed_en = 1'b0;

    $display("[TB] 4-beat write with gapped data");
    apply_stimulus(1, 32'h200, 3, 4'hF, 0, -1, 0, 0, 3);
    verify_cmd("burst_wr");

    $display("[TB] 4-beat zero-wait read");
    apply_stimulus(0, 32'h40, 3, 4'hF, 0, -1, 0, 0, 0);
    verify_cmd("zw_rd");

    $display("[TB] error on beat 2, then ack+err together");
    apply_stimulus(0, 32'h300, 3, 4'hF, 1, 1, 0, 0, 0);
    verify_cmd("err_beat2");
    apply_stimulus(0, 32'h380, 0, 4'h3, 0, 0, 1, 0, 0);
    verify_cmd("ack_err_same");

    $display("[TB] silent slave timeout, then immediate new command");
    apply_stimulus(0, 32'h500, 0, 4'hF, 0, -1, 0, 1, 0);
    verify_cmd("timeout");
    apply_stimulus(0, 32'h600, 1, 4'hF, 0, -1, 0, 0, 0);
    verify_cmd("after_timeout");

    $display("[TB] address wrap");
    apply_stimulus(0, 32'hFFFF_FFFC, 1, 4'hF, 0, -1, 0, 0, 0);
    verify_cmd("wrap");
    if (log_adr.size() > 1) check_output("wrap_second_adr", log_adr[1], 32'h0);

    $display("[TB] reset during beat 2");
    apply_stimulus(0, 32'h700, 3, 4'hF, 1, -1, 0, 0, 0);
    g = 0;
    while (beat < 1 && g < 100) begin
      @(negedge clk_i);
      g++;
    end
    check_output("rst_reached_beat2", beat >= 1, 1);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    check_output("rst_mid_bus", {cyc_o, stb_o, done_o, cmd_ready_o}, 4'b0001);
    repeat (4) @(negedge clk_i);
    check_output("rst_mid_no_done", done_cnt, 0);

    $display("[TB] randomized commands");
    for (int k = 0; k < 8; k++) begin
      bit r_we;
      int r_len, r_err;
      r_we  = 1'($urandom);
      r_len = $urandom_range(0, 5);
      r_err = ($urandom_range(0, 3) == 0) ? $urandom_range(0, r_len) : -1;
      apply_stimulus(r_we, $urandom & 32'hFFFF_FFFC, r_len, 4'($urandom_range(1, 15)),
                     $urandom_range(0, 2), r_err, 1'($urandom), 0, $urandom_range(0, 2));
      verify_cmd($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
